// File: rtl/bcd_convert_sched_if.sv
// Request/acknowledge and result bundle for the shared binary-to-BCD engine.
// The requester side drives req/val; the engine drives acks and the result.
interface bcd_convert_sched_if #(
  parameter int WIDTH = 14
);
  logic             req0;
  logic [WIDTH-1:0] val0;
  logic             req1;
  logic [WIDTH-1:0] val1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [15:0]      bcd;
  logic             ovf;

  modport master (
    output req0, val0, req1, val1,
    input  ack0, ack1, busy, done, done_id, bcd, ovf
  );

  modport slave (
    input  req0, val0, req1, val1,
    output ack0, ack1, busy, done, done_id, bcd, ovf
  );
endinterface

// File: rtl/bcd_convert_sched.sv
// Round-robin shared converter: 14-bit binary to 4-digit BCD by repeated
// subtraction of 1000, 100 and 10, one subtraction per clock.
module bcd_convert_sched #(
  parameter int WIDTH  = 14,
  parameter int MAXVAL = 9999
) (
  input  logic               clk,
  input  logic               rst,
  bcd_convert_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t           state, state_next;
  logic             ptr;
  logic [WIDTH-1:0] work;
  logic [1:0]       idx;
  logic [3:0]       cnt;
  logic [3:0]       dig3, dig2;
  logic             id;
  logic             ovf_stage;
  logic [15:0]      bcd_q;
  logic             id_q;
  logic             ovf_q;

  logic             grant0, grant1, take, last_digit;
  logic [WIDTH-1:0] sel_val, clamped, divisor;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    // With both requesting, the one that was not served last wins.
    grant0     = bus.req0 && (!bus.req1 || ptr);
    grant1     = bus.req1 && (!bus.req0 || !ptr);
    take       = (state == IDLE) && !rst && (grant0 || grant1);
    sel_val    = grant1 ? bus.val1 : bus.val0;
    clamped    = (sel_val > WIDTH'(MAXVAL)) ? WIDTH'(MAXVAL) : sel_val;
    case (idx)
      2'd3:    divisor = WIDTH'(1000);
      2'd2:    divisor = WIDTH'(100);
      default: divisor = WIDTH'(10);
    endcase
    last_digit = (state == SUB) && (work < divisor) && (idx == 2'd1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = SUB;
      SUB:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b1;
      work      <= '0;
      idx       <= '0;
      cnt       <= '0;
      dig3      <= '0;
      dig2      <= '0;
      id        <= 1'b0;
      ovf_stage <= 1'b0;
      bcd_q     <= '0;
      id_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          work      <= clamped;
          ovf_stage <= (sel_val > WIDTH'(MAXVAL));
          idx       <= 2'd3;
          cnt       <= '0;
          id        <= grant1;
          ptr       <= grant1;
        end
        SUB: if (work >= divisor) begin
          work <= work - divisor;
          cnt  <= cnt + 4'd1;
        end else begin
          cnt <= '0;
          idx <= idx - 2'd1;
          case (idx)
            2'd3: dig3 <= cnt;
            2'd2: dig2 <= cnt;
            default: begin
              // Remainder is below 10 here, so it is the ones digit directly.
              bcd_q <= {dig3, dig2, cnt, work[3:0]};
              id_q  <= id;
              ovf_q <= ovf_stage;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0    = take && grant0;
  assign bus.ack1    = take && grant1;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = id_q;
  assign bus.bcd     = bcd_q;
  assign bus.ovf     = ovf_q;
endmodule
